regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised general-purpose register file with forwarding. It has NRD combinational read ports and one byte-enabled write-back port. Each read port has a byte-granular forwarding network over NFWD in-flight pipeline stages. A pending-write scoreboard interlocks long-latency producers (loads, mul/div). It replaces the fixed two-port, two-stage register file in the decode stage of the core, and adds a saturating stall-cycle counter for performance monitoring.

## Interface
- DW, 32, data width in bits; multiple of 8; NB = DW/8 byte lanes
- NREG, 32, number of registers; register 0 hardwired to zero
- AW, 5, register address width; NREG = 2**AW
- NRD, 2, number of read ports
- NFWD, 2, forwarding stages; index 0 = youngest (EX), highest priority
- CW, 32, stall counter width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- re  in  NRD  per-port read enable
- raddr  in  NRD*AW  read addresses, port p at [p*AW +: AW]
- rdata  out  NRD*DW  read data, combinational
- we  in  NB  write-back byte enables
- waddr  in  AW  write-back address
- wdata  in  DW  write-back data
- fwd_we  in  NFWD*NB  per-stage byte enables
- fwd_addr  in  NFWD*AW  per-stage destination
- fwd_data  in  NFWD*DW  per-stage result
- sb_set  in  1  issue of long-latency producer
- sb_set_addr  in  AW  its destination
- sb_clr  in  1  final write-back of that producer, same cycle as its we
- sb_clr_addr  in  AW  register being released
- hazard  out  NFWD  bit s: some enabled, valid read port hits stage s
- busy_stall  out  1  some enabled, valid read port targets a pending register
- stall_cnt  out  CW  saturating count of cycles with busy_stall=1
- stall_cnt_clr  in  1  zero stall_cnt

## Operation
- Storage: NREG×DW flops. On a write, each byte lane with we[b]=1 and waddr≠0 is updated. Register 0 is never written and always reads 0.
- Read valid: v[p] = re[p] && raddr[p]≠0. If v[p]=0, rdata[p] = 0 on all lanes.
- Per lane b, per valid port, take the first match in this order:
  1. fwd stage 0
  2. fwd stage 1 … NFWD-1
  3. write-back (we[b] && waddr==raddr[p])
  4. stored value
- A stage matches lane b when fwd_we[s][b]=1 and fwd_addr[s]==raddr[p]. Byte enables are evaluated independently per lane. A partial write in a younger stage therefore merges with bytes taken from older stages or storage.
- hazard[s] = OR over p of (v[p] && stage s matches any lane). It is informational; the pipeline uses it for load-use stall decisions.
- Scoreboard: one busy bit per register, bit 0 always 0.
  - sb_set sets busy[sb_set_addr]; address 0 is ignored.
  - sb_clr clears busy[sb_clr_addr].
  - Set and clear of the same address in the same cycle: set wins.
- busy_stall = OR over p of (v[p] && busy[raddr[p]] && !(sb_clr && sb_clr_addr==raddr[p])). A read in the clearing cycle does not stall; its data arrives through the write-back bypass.
- stall_cnt increments by 1 each cycle busy_stall=1 and holds at 2**CW−1. stall_cnt_clr has priority over increment.

## Timing
- Reads, hazard and busy_stall are combinational from the current inputs and state, with zero latency.
- Writes, busy-bit changes and stall_cnt update at the rising edge. A write is visible from storage in the next cycle and through the write-back bypass in the same cycle.
- Reset (rst=1 at an edge) clears all registers to 0, all busy bits to 0 and stall_cnt to 0. While rst=1, writes, sb_set and sb_clr are ignored.
- Outputs during and after reset:
  - rdata = 0 on every port unless forwarding is active.
  - hazard = 0 when fwd_we = 0.
  - busy_stall = 0 and stall_cnt = 0.
- Reset asserted mid-operation discards all pending scoreboard state. Producers still in flight must be flushed by the pipeline.

## Test plan
- Write x5 = 0x11223344 with we=4'hF. The next cycle, read port 0 from x5 returns 0x11223344. Reading x0 after writing 0xFFFFFFFF to it returns 0.
- Stored x7 = 0xAAAAAAAA; stage 0 has fwd_we=4'b0001, data 0x000000BB; stage 1 has fwd_we=4'b0110, data 0x00CCDD00. Read x7 -> 0xAACCDDBB, and hazard = 2'b11.
- Stored x3 = 0; stage 1 has 0x12345678 with we=4'hF; write-back has 0x9ABCDEF0. Read x3 on both ports -> 0x12345678 on both, hazard = 2'b10.
- sb_set for x9, then read x9 for 3 cycles -> busy_stall=1 and stall_cnt=3. In the next cycle, sb_clr for x9 with write-back 0x55 -> busy_stall=0 and rdata=0x55.
- In the same cycle, sb_set and sb_clr target x4 -> busy[x4]=1 afterwards. sb_set to x0 -> never stalls.
- Hold busy_stall=1 with CW=4 for 20 cycles -> stall_cnt saturates at 15. Assert rst mid-stream -> all state 0 the next cycle.

Source files
------------

// File: rtl/regfile_mp.sv
// regfile_mp -- multi-port general-purpose register file with byte-granular
// forwarding and a pending-write scoreboard.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   re, raddr       per-port read enable and address (port p at [p*AW +: AW])
//   rdata           combinational read data (port p at [p*DW +: DW])
//   we, waddr, wdata  byte-enabled write-back port
//   fwd_we, fwd_addr, fwd_data  in-flight results, stage 0 = youngest
//   sb_set, sb_set_addr  mark a register as pending (long-latency producer)
//   sb_clr, sb_clr_addr  release a pending register (same cycle as its we)
//   hazard          bit s: a valid read port hits forwarding stage s
//   busy_stall      a valid read port targets a pending register
//   stall_cnt       saturating count of busy_stall cycles
//   stall_cnt_clr   zero stall_cnt (wins over increment)
module regfile_mp #(
  parameter int DW   = 32,
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int NRD  = 2,
  parameter int NFWD = 2,
  parameter int CW   = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NRD-1:0]         re,
  input  logic [NRD*AW-1:0]      raddr,
  output logic [NRD*DW-1:0]      rdata,
  input  logic [DW/8-1:0]        we,
  input  logic [AW-1:0]          waddr,
  input  logic [DW-1:0]          wdata,
  input  logic [NFWD*(DW/8)-1:0] fwd_we,
  input  logic [NFWD*AW-1:0]     fwd_addr,
  input  logic [NFWD*DW-1:0]     fwd_data,
  input  logic                   sb_set,
  input  logic [AW-1:0]          sb_set_addr,
  input  logic                   sb_clr,
  input  logic [AW-1:0]          sb_clr_addr,
  output logic [NFWD-1:0]        hazard,
  output logic                   busy_stall,
  output logic [CW-1:0]          stall_cnt,
  input  logic                   stall_cnt_clr
);

  localparam int NB = DW / 8;

  logic [DW-1:0]   regs [NREG];
  logic [NREG-1:0] busy;
  logic [CW-1:0]   cnt_q;

  logic [AW-1:0]   ra [NRD];
  logic [NRD-1:0]  rd_vld;
  logic [NB-1:0]   wb_en;
  logic [7:0]      lane;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (&c) ? c : c + CW'(1);
  endfunction

  // Writes and scoreboard updates are suppressed while reset is held, so the
  // write-back bypass must be suppressed as well to stay consistent.
  assign wb_en = rst ? '0 : we;

  always_comb begin
    for (int p = 0; p < NRD; p++) begin
      ra[p]     = raddr[p*AW +: AW];
      rd_vld[p] = re[p] && (ra[p] != '0);
    end
  end

  // Read network: per lane, start from storage and overlay sources in
  // increasing priority so that the youngest matching stage ends up winning.
  always_comb begin
    rdata      = '0;
    hazard     = '0;
    busy_stall = 1'b0;
    lane       = '0;
    for (int p = 0; p < NRD; p++) begin
      if (rd_vld[p]) begin
        for (int b = 0; b < NB; b++) begin
          lane = rst ? 8'h00 : regs[ra[p]][b*8 +: 8];
          if (wb_en[b] && (waddr == ra[p]))
            lane = wdata[b*8 +: 8];
          for (int s = NFWD - 1; s >= 0; s--) begin
            if (fwd_we[s*NB + b] && (fwd_addr[s*AW +: AW] == ra[p]))
              lane = fwd_data[s*DW + b*8 +: 8];
          end
          rdata[p*DW + b*8 +: 8] = lane;
        end
        for (int s = 0; s < NFWD; s++) begin
          if ((|fwd_we[s*NB +: NB]) && (fwd_addr[s*AW +: AW] == ra[p]))
            hazard[s] = 1'b1;
        end
        // A register released this cycle is served by the write-back bypass.
        if (!rst && busy[ra[p]] && !(sb_clr && (sb_clr_addr == ra[p])))
          busy_stall = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++)
        regs[r] <= '0;
    end else if (waddr != '0) begin
      for (int b = 0; b < NB; b++) begin
        if (we[b])
          regs[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  // Set is applied after clear so that a same-address set/clear leaves the
  // register pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      if (sb_clr)
        busy[sb_clr_addr] <= 1'b0;
      if (sb_set && (sb_set_addr != '0))
        busy[sb_set_addr] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      cnt_q <= '0;
    else if (stall_cnt_clr)
      cnt_q <= '0;
    else if (busy_stall)
      cnt_q <= sat_inc(cnt_q);
  end

  assign stall_cnt = rst ? '0 : cnt_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Testbench for regfile_mp (DW=32, NRD=2, NFWD=2, CW=4): directed vector
// table, hand-written scoreboard/counter sequences and randomized cycles
// checked against a behavioural model.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  re;
  logic [9:0]  raddr;
  logic [63:0] rdata;
  logic [3:0]  we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [7:0]  fwd_we;
  logic [9:0]  fwd_addr;
  logic [63:0] fwd_data;
  logic        sb_set;
  logic [4:0]  sb_set_addr;
  logic        sb_clr;
  logic [4:0]  sb_clr_addr;
  logic [1:0]  hazard;
  logic        busy_stall;
  logic [3:0]  stall_cnt;
  logic        stall_cnt_clr;

  int tests = 0;
  int fails = 0;

  // behavioural model state
  logic [31:0] m_reg  [32];
  bit          m_busy [32];
  int          m_cnt;

  regfile_mp #(.DW(32), .NREG(32), .AW(5), .NRD(2), .NFWD(2), .CW(4)) dut (
    .clk(clk), .rst(rst), .re(re), .raddr(raddr), .rdata(rdata),
    .we(we), .waddr(waddr), .wdata(wdata),
    .fwd_we(fwd_we), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
    .sb_set(sb_set), .sb_set_addr(sb_set_addr),
    .sb_clr(sb_clr), .sb_clr_addr(sb_clr_addr),
    .hazard(hazard), .busy_stall(busy_stall), .stall_cnt(stall_cnt),
    .stall_cnt_clr(stall_cnt_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  re;
    logic [9:0]  raddr;
    logic [3:0]  we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [7:0]  fwd_we;
    logic [9:0]  fwd_addr;
    logic [63:0] fwd_data;
    logic [63:0] e_rdata;
    logic [1:0]  e_haz;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] exp_rdata();
    logic [63:0] r = '0;
    for (int p = 0; p < 2; p++) begin
      logic [4:0] a = raddr[p*5 +: 5];
      if (re[p] && a != 0) begin
        for (int b = 0; b < 4; b++) begin
          logic [7:0] v = 8'h00;
          bit found = 0;
          for (int s = 0; s < 2; s++)
            if (!found && fwd_we[s*4+b] && fwd_addr[s*5 +: 5] == a) begin
              v = fwd_data[s*32 + b*8 +: 8];
              found = 1;
            end
          if (!found && !rst && we[b] && waddr == a) begin
            v = wdata[b*8 +: 8];
            found = 1;
          end
          if (!found && !rst) v = m_reg[a][b*8 +: 8];
          r[p*32 + b*8 +: 8] = v;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [1:0] exp_hazard();
    logic [1:0] h = '0;
    for (int p = 0; p < 2; p++)
      for (int s = 0; s < 2; s++)
        if (re[p] && raddr[p*5 +: 5] != 0 && fwd_addr[s*5 +: 5] == raddr[p*5 +: 5]
            && fwd_we[s*4 +: 4] != 0)
          h[s] = 1'b1;
    return h;
  endfunction

  function automatic bit exp_stall();
    bit st = 0;
    if (rst) return 0;
    for (int p = 0; p < 2; p++) begin
      logic [4:0] a = raddr[p*5 +: 5];
      if (re[p] && a != 0 && m_busy[a] && !(sb_clr && sb_clr_addr == a)) st = 1;
    end
    return st;
  endfunction

  task automatic model_update();
    bit st;
    if (rst) begin
      for (int r = 0; r < 32; r++) begin
        m_reg[r]  = '0;
        m_busy[r] = 0;
      end
      m_cnt = 0;
    end else begin
      st = exp_stall();
      if (stall_cnt_clr) m_cnt = 0;
      else if (st && m_cnt < 15) m_cnt++;
      if (waddr != 0)
        for (int b = 0; b < 4; b++)
          if (we[b]) m_reg[waddr][b*8 +: 8] = wdata[b*8 +: 8];
      if (sb_clr) m_busy[sb_clr_addr] = 0;
      if (sb_set && sb_set_addr != 0) m_busy[sb_set_addr] = 1;
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".rdata"}, rdata, exp_rdata());
    chk({tag, ".hazard"}, {62'd0, hazard}, {62'd0, exp_hazard()});
    chk({tag, ".busy_stall"}, {63'd0, busy_stall}, {63'd0, exp_stall()});
    chk({tag, ".stall_cnt"}, {60'd0, stall_cnt}, rst ? 64'd0 : 64'(m_cnt));
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle();
    re = '0; raddr = '0; we = '0; waddr = '0; wdata = '0;
    fwd_we = '0; fwd_addr = '0; fwd_data = '0;
    sb_set = 0; sb_set_addr = '0; sb_clr = 0; sb_clr_addr = '0;
    stall_cnt_clr = 0;
  endtask

  task automatic read_p0(input logic [4:0] a);
    re = 2'b01; raddr = {5'd0, a};
  endtask

  initial begin
    rst = 1'b1;
    idle();
    for (int r = 0; r < 32; r++) begin m_reg[r] = 'x; m_busy[r] = 0; end
    m_cnt = 0;
    @(negedge clk);
    tick();
    tick();
    rst = 1'b0;

    // reset state
    re = 2'b11; raddr = {5'd5, 5'd9};
    #2;
    chk("reset.rdata", rdata, 64'd0);
    chk("reset.hazard", {62'd0, hazard}, 64'd0);
    chk("reset.busy_stall", {63'd0, busy_stall}, 64'd0);
    chk("reset.stall_cnt", {60'd0, stall_cnt}, 64'd0);
    idle();

    // preload storage
    we = 4'hF; waddr = 5'd5; wdata = 32'h11223344; tick();
    we = 4'hF; waddr = 5'd7; wdata = 32'hAAAAAAAA; tick();
    idle();

    tbl[0] = '{2'b01, {5'd0, 5'd5}, 4'h0, 5'd0, 32'h0, 8'h00, 10'd0, 64'h0,
               {32'h0, 32'h11223344}, 2'b00};
    tbl[1] = '{2'b01, {5'd0, 5'd7}, 4'h0, 5'd0, 32'h0, {4'b0110, 4'b0001}, {5'd7, 5'd7},
               {32'h00CCDD00, 32'h000000BB}, {32'h0, 32'hAACCDDBB}, 2'b11};
    tbl[2] = '{2'b11, {5'd3, 5'd3}, 4'hF, 5'd3, 32'h9ABCDEF0, {4'b1111, 4'b0000}, {5'd3, 5'd0},
               {32'h12345678, 32'h0}, {32'h12345678, 32'h12345678}, 2'b10};
    tbl[3] = '{2'b10, {5'd3, 5'd0}, 4'h0, 5'd0, 32'h0, 8'h00, 10'd0, 64'h0,
               {32'h9ABCDEF0, 32'h0}, 2'b00};
    tbl[4] = '{2'b01, {5'd0, 5'd0}, 4'hF, 5'd0, 32'hFFFFFFFF, 8'h00, 10'd0, 64'h0,
               64'h0, 2'b00};
    tbl[5] = '{2'b11, {5'd5, 5'd0}, 4'h0, 5'd0, 32'h0, 8'h00, 10'd0, 64'h0,
               {32'h11223344, 32'h0}, 2'b00};
    tbl[6] = '{2'b00, {5'd5, 5'd5}, 4'h0, 5'd0, 32'h0, {4'b0000, 4'b1111}, {5'd0, 5'd5},
               {32'h0, 32'hDEADBEEF}, 64'h0, 2'b00};
    tbl[7] = '{2'b10, {5'd5, 5'd0}, 4'b0011, 5'd5, 32'h0000BEEF, 8'h00, 10'd0, 64'h0,
               {32'h1122BEEF, 32'h0}, 2'b00};
    tbl[8] = '{2'b01, {5'd0, 5'd5}, 4'h0, 5'd0, 32'h0, {4'b1000, 4'b0000}, {5'd5, 5'd0},
               {32'h77000000, 32'h0}, {32'h0, 32'h7722BEEF}, 2'b10};
    tbl[9] = '{2'b01, {5'd0, 5'd0}, 4'h0, 5'd0, 32'h0, {4'b0000, 4'b1111}, {5'd0, 5'd0},
               {32'h0, 32'h12345678}, 64'h0, 2'b00};

    for (int i = 0; i < 10; i++) begin
      idle();
      re = tbl[i].re; raddr = tbl[i].raddr; we = tbl[i].we; waddr = tbl[i].waddr;
      wdata = tbl[i].wdata; fwd_we = tbl[i].fwd_we; fwd_addr = tbl[i].fwd_addr;
      fwd_data = tbl[i].fwd_data;
      #2;
      chk($sformatf("vec%0d.rdata", i), rdata, tbl[i].e_rdata);
      chk($sformatf("vec%0d.hazard", i), {62'd0, hazard}, {62'd0, tbl[i].e_haz});
      tick();
    end

    // scoreboard: pending x9 stalls, released by write-back without stalling
    idle(); stall_cnt_clr = 1; tick();
    idle(); sb_set = 1; sb_set_addr = 5'd9; tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      read_p0(5'd9);
      #2 chk($sformatf("sb.stall%0d", i), {63'd0, busy_stall}, 64'd1);
      tick();
    end
    read_p0(5'd9); sb_clr = 1; sb_clr_addr = 5'd9; we = 4'hF; waddr = 5'd9; wdata = 32'h55;
    #2;
    chk("sb.clr_stall", {63'd0, busy_stall}, 64'd0);
    chk("sb.clr_rdata", rdata, 64'h55);
    chk("sb.cnt3", {60'd0, stall_cnt}, 64'd3);
    tick();
    idle(); read_p0(5'd9);
    #2;
    chk("sb.after_rdata", rdata, 64'h55);
    chk("sb.after_stall", {63'd0, busy_stall}, 64'd0);
    tick();

    // set and clear of the same register: set wins
    idle(); sb_set = 1; sb_set_addr = 5'd4; sb_clr = 1; sb_clr_addr = 5'd4; tick();
    idle(); read_p0(5'd4);
    #2 chk("sb.set_wins", {63'd0, busy_stall}, 64'd1);
    tick();
    idle(); sb_clr = 1; sb_clr_addr = 5'd4; tick();
    idle(); sb_set = 1; sb_set_addr = 5'd0; tick();
    idle(); re = 2'b11; raddr = {5'd0, 5'd0};
    #2 chk("sb.x0_nostall", {63'd0, busy_stall}, 64'd0);
    tick();

    // saturation, clear priority, then reset mid-stream
    idle(); stall_cnt_clr = 1; sb_set = 1; sb_set_addr = 5'd9; tick();
    idle();
    for (int i = 0; i < 20; i++) begin read_p0(5'd9); tick(); end
    read_p0(5'd9);
    #2 chk("sat.cnt15", {60'd0, stall_cnt}, 64'd15);
    stall_cnt_clr = 1; tick();
    stall_cnt_clr = 0;
    #2 chk("sat.clr_wins", {60'd0, stall_cnt}, 64'd0);
    tick();
    rst = 1;
    #2 chk("rst.during_stall", {63'd0, busy_stall}, 64'd0);
    tick();
    rst = 0; re = 2'b11; raddr = {5'd5, 5'd9};
    #2;
    chk("rst.rdata", rdata, 64'd0);
    chk("rst.busy_stall", {63'd0, busy_stall}, 64'd0);
    chk("rst.stall_cnt", {60'd0, stall_cnt}, 64'd0);
    tick();

    // randomized cycles against the model
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 49) == 0);
      re = 2'($urandom);
      raddr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      we = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
      waddr = 5'($urandom_range(0, 7));
      wdata = $urandom;
      fwd_we = {($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom),
                ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom)};
      fwd_addr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      fwd_data = {$urandom, $urandom};
      sb_set = ($urandom_range(0, 3) == 0);
      sb_set_addr = 5'($urandom_range(0, 7));
      sb_clr = ($urandom_range(0, 3) == 0);
      sb_clr_addr = 5'($urandom_range(0, 7));
      stall_cnt_clr = ($urandom_range(0, 29) == 0);
      #2 check_model($sformatf("rnd%0d", i));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
